// File: rtl/mem_ctrl_3do.sv
// Wishbone slave terminating ZAP bus cycles: forwards DRAM/VRAM/BIOS accesses to a req/ready
// memory port, acks MADAM/CLIO windows after REG_WAIT cycles. Optional macro MEM_TIMEOUT_EN.
module mem_ctrl_3do #(
  parameter int REG_WAIT    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_sys_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat_w,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat_r,
  output logic        o_wb_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [1:0]  o_mem_region,
  output logic [18:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_overlay,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_MREQ, S_REGW, S_ACK} state_e;

  localparam logic [1:0] RGN_DRAM = 2'd0;
  localparam logic [1:0] RGN_VRAM = 2'd1;
  localparam logic [1:0] RGN_ROM  = 2'd2;

  if (REG_WAIT < 1 || REG_WAIT > 15) begin : g_bad_reg_wait
    $error("mem_ctrl_3do: REG_WAIT must be in 1..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_ctrl_3do: TIMEOUT_CYC must be at least 1");
  end

  state_e      r_state;
  logic [3:0]  r_wcnt;
  logic        r_abort;

  logic        w_hit_dram;
  logic        w_hit_vram;
  logic        w_hit_rom;
  logic        w_hit_reg;
  logic        w_null_wr;
  logic        w_rom_wr;
  logic        w_is_mem;
  logic        w_go_mem;
  logic        w_go_reg;
  logic        w_accept;
  logic        w_abort;
  logic [1:0]  w_region;
  logic [18:0] w_maddr;
  logic        w_unused_adr;

  assign w_unused_adr = ^i_wb_adr[1:0];

  assign w_hit_dram = (i_wb_adr[31:21] == 11'd0);
  assign w_hit_vram = (i_wb_adr[31:20] == 12'h002);
  assign w_hit_rom  = (i_wb_adr[31:20] == 12'h030);
  assign w_hit_reg  = (i_wb_adr[31:16] == 16'h0330) || (i_wb_adr[31:16] == 16'h0340);
  assign w_null_wr  = i_wb_we && (i_wb_sel == 4'd0);
  assign w_rom_wr   = w_hit_rom && i_wb_we;
  assign w_go_mem   = w_is_mem && !w_null_wr;
  assign w_go_reg   = w_hit_reg && !w_null_wr;
  // The cycle in which ack is high still shows the finished transfer's stb; never re-accept it.
  assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_ack;
  assign w_abort    = r_abort || !i_wb_cyc;

  always_comb begin
    w_is_mem = 1'b0;
    w_region = RGN_DRAM;
    w_maddr  = 19'd0;
    if (w_hit_dram) begin
      w_is_mem = 1'b1;
      // Boot overlay: reads of the low 1 MB come from BIOS until the first ROM write.
      if (o_overlay && !i_wb_we && !i_wb_adr[20]) begin
        w_region = RGN_ROM;
        w_maddr  = {1'b0, i_wb_adr[19:2]};
      end else begin
        w_maddr  = i_wb_adr[20:2];
      end
    end else if (w_hit_vram) begin
      w_is_mem = 1'b1;
      w_region = RGN_VRAM;
      w_maddr  = {1'b0, i_wb_adr[19:2]};
    end else if (w_hit_rom && !i_wb_we) begin
      w_is_mem = 1'b1;
      w_region = RGN_ROM;
      w_maddr  = {1'b0, i_wb_adr[19:2]};
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] r_to_cnt;
`else
  assign o_bus_err = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_wcnt       <= 4'd0;
      r_abort      <= 1'b0;
      o_wb_ack     <= 1'b0;
      o_wb_dat_r   <= 32'd0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_region <= RGN_DRAM;
      o_mem_addr   <= 19'd0;
      o_mem_wdata  <= 32'd0;
      o_mem_be     <= 4'd0;
      o_overlay    <= 1'b1;
`ifdef MEM_TIMEOUT_EN
      r_to_cnt     <= '0;
      o_bus_err    <= 1'b0;
`endif
    end else begin
      o_wb_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_abort <= 1'b0;
            if (w_rom_wr) o_overlay <= 1'b0;
            if (w_go_mem) begin
              o_mem_req    <= 1'b1;
              o_mem_we     <= i_wb_we;
              o_mem_region <= w_region;
              o_mem_addr   <= w_maddr;
              o_mem_wdata  <= i_wb_dat_w;
              o_mem_be     <= i_wb_sel;
`ifdef MEM_TIMEOUT_EN
              r_to_cnt     <= '0;
`endif
              r_state      <= S_MREQ;
            end else if (w_go_reg) begin
              if (!i_wb_we) o_wb_dat_r <= 32'd0;
              r_wcnt  <= 4'(REG_WAIT - 1);
              r_state <= S_REGW;
            end else begin
              if (!i_wb_we) o_wb_dat_r <= 32'd0;
              r_state <= S_ACK;
            end
          end
        end

        // Memory transaction always runs to completion; a dropped cyc only suppresses the ack.
        S_MREQ: begin
          if (!i_wb_cyc) r_abort <= 1'b1;
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            if (!o_mem_we) o_wb_dat_r <= i_mem_rdata;
            r_state <= w_abort ? S_IDLE : S_ACK;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            o_mem_req <= 1'b0;
            o_bus_err <= 1'b1;
            if (!o_mem_we) o_wb_dat_r <= 32'hDEAD_BEEF;
            r_state <= w_abort ? S_IDLE : S_ACK;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end

        S_REGW: begin
          if (!i_wb_cyc) r_abort <= 1'b1;
          if (r_wcnt == 4'd0) begin
            r_state <= w_abort ? S_IDLE : S_ACK;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end

        S_ACK: begin
          o_wb_ack <= 1'b1;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl_3do.md
Name: mem_ctrl_3do

Overview:
Wishbone slave that terminates every CPU bus cycle leaving the core's ZAP master.
- DRAM, VRAM and BIOS accesses are forwarded to a single req/ready backing-memory port (SDRAM controller or sim model), with a region tag.
- MADAM/CLIO register windows get a fixed-latency ack; their data is muxed in the core, not here.
- Implements the boot-time BIOS overlay at address 0.
- Provides the core's i_wb_ack and i_wb_dat.

Parameters:
- REG_WAIT, 2, cycles from accepted stb to ack for the MADAM/CLIO windows (1..15).
- TIMEOUT_CYC, 255, cycles mem_req may stay unanswered before a forced ack (only with MEM_TIMEOUT_EN).

Ports:
- sys_clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- wb_adr  in  32  byte address
- wb_dat_w  in  32  write data
- wb_sel  in  4  byte lanes
- wb_we  in  1  write enable
- wb_cyc  in  1  cycle valid
- wb_stb  in  1  strobe
- wb_dat_r  out  32  read data, valid with wb_ack
- wb_ack  out  1  single-cycle acknowledge
- mem_req  out  1  backing-memory request
- mem_we  out  1  write
- mem_region  out  2  0=DRAM, 1=VRAM, 2=ROM
- mem_addr  out  19  word address within region
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid when mem_ready
- mem_ready  in  1  completes the request
- overlay  out  1  BIOS overlay active
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset values (async, reset_n low): wb_ack=0, wb_dat_r=0, mem_req=0, mem_we=0, mem_region=0, mem_addr=0, mem_wdata=0, mem_be=0, overlay=1, bus_err=0, FSM=IDLE. An in-flight mem_req drops immediately; no ack is issued after release.
- Address decode, in priority order:
  - DRAM 0x00000000-0x001FFFFF: region 0, mem_addr=adr[20:2]. While overlay=1, reads of 0x00000000-0x000FFFFF go to region 2 instead (writes still go to DRAM).
  - VRAM 0x00200000-0x002FFFFF: region 1, mem_addr={1'b0, adr[19:2]}.
  - ROM 0x03000000-0x030FFFFF: region 2, mem_addr={1'b0, adr[19:2]}.
  - REG 0x03300000-0x0330FFFF and 0x03400000-0x0340FFFF: no memory request.
  - Anything else: unmapped.
- FSM states: IDLE, MREQ, REGW, ACK.
- IDLE:
  - Accepts when wb_cyc&wb_stb; decode and all mem_* outputs are registered on that edge.
  - Memory region -> MREQ with mem_req=1.
  - REG -> REGW, counter loaded with REG_WAIT-1.
  - Unmapped read, ROM write, or write with wb_sel=0 -> ACK with no memory request. Read data 0; write data discarded.
  - Any ROM-region write clears overlay permanently until reset.
- MREQ: mem_req and all mem_* outputs held stable until mem_ready=1. On that edge: mem_req=0, mem_rdata is captured into wb_dat_r on reads (wb_dat_r is left unchanged on writes), go to ACK.
- REGW: counter decrements; at 0 go to ACK.
- ACK: wb_ack=1 for exactly one cycle, then IDLE. A new stb is not accepted in the ACK cycle, so back-to-back transfers are spaced ≥1 idle cycle.
- Memory latency: stb sampled at edge 0 -> mem_req high after edge 0 -> mem_ready same cycle -> wb_ack high after edge 2. REG latency is REG_WAIT+1 cycles.
- wb_cyc dropped while in MREQ: the memory transaction completes (never aborted), but the ack is suppressed and the FSM returns to IDLE. Same rule applies in REGW.
- mem_ready while mem_req=0: ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter runs in MREQ. If mem_ready has not arrived after TIMEOUT_CYC cycles:
  - mem_req drops;
  - wb_dat_r=32'hDEADBEEF on reads;
  - wb_ack is issued normally;
  - bus_err is set sticky until reset.
  - A mem_ready arriving on the same edge as the timeout wins (normal completion).
- Undefined: MREQ waits indefinitely; bus_err is tied 0.

Test Plan:
- Reset, then read 0x00000010 with mem_ready on the first req cycle and mem_rdata=0xE59FF018 -> mem_region=2, mem_addr=4, wb_dat_r=0xE59FF018, wb_ack high after edge 2, one cycle wide.
- Write 0x03000000 sel=F -> no mem_req, ack, overlay=0. Then read 0x00000010 -> mem_region=0, mem_addr=4.
- Write 0x00200404 data 0x12345678 sel=0x3, mem_ready delayed 5 cycles -> mem_req high 5 cycles with mem_we=1, mem_region=1, mem_addr=0x101, mem_be=0x3, data stable; then one ack.
- Read 0x03400028 with REG_WAIT=2 -> no mem_req, wb_ack exactly 3 cycles after stb. Read 0x05000000 -> ack with wb_dat_r=0.
- Drop wb_cyc during MREQ, then mem_ready -> no wb_ack, FSM IDLE. Assert reset_n low mid-MREQ -> mem_req falls asynchronously, overlay=1.
- With MEM_TIMEOUT_EN and TIMEOUT_CYC=8, never assert mem_ready -> ack with 0xDEADBEEF, bus_err=1 and stays 1 after a subsequent good access.
